// File: rtl/fu_alu_issue_ctrl.sv
// fu_alu_issue_ctrl
// Issue-side controller for the single-cycle ALU functional unit. It takes one
// decoded operation at a time, fires the FU with a one-cycle enable, waits
// for the FU finish pulse, and queues {tag, result, zero, overflow} in a small
// circular FIFO that feeds register writeback.
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid & ready are both 1. A producer holds valid, and its payload stays
// stable, until that transfer happens. The controller derives issue_ready only
// from its own state (state and FIFO count), never from issue_valid. wb_valid
// is derived only from FIFO occupancy, never from wb_ready.
module fu_alu_issue_ctrl #(
  parameter int TAG_W    = 5,
  parameter int WB_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_ctrl,
  input  logic [31:0]      issue_a,
  input  logic [31:0]      issue_b,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             fu_en,
  output logic [3:0]       fu_ctrl,
  output logic [31:0]      fu_a,
  output logic [31:0]      fu_b,
  input  logic [31:0]      fu_res,
  input  logic             fu_zero,
  input  logic             fu_overflow,
  input  logic             fu_finish,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  output logic             wb_zero,
  output logic             wb_overflow,
  output logic             busy,
  output logic [15:0]      done_cnt
);

  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + 34;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WB_DEPTH);

  // Operation sequencing: IDLE waits for an offer, ISSUE fires the FU once,
  // WAIT holds until the FU reports completion.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [TAG_W-1:0] tag_q;

  // Result FIFO: entries are packed {tag, data, zero, overflow}.
  logic [ENT_W-1:0] mem [WB_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] head;

  logic accept;
  logic push;
  logic pop;

  // Only one operation is ever in flight. Gating acceptance on free space
  // guarantees that the WAIT-state push always finds room.
  assign issue_ready = (state == ST_IDLE) && (count < DEPTH_C);
  assign accept      = issue_valid && issue_ready;

  // finish is only meaningful while WAIT is active; stray pulses are ignored.
  assign push = (state == ST_WAIT) && fu_finish;
  assign pop  = wb_valid && wb_ready;

  // Controller FSM with registered FU drive, operand latch and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      fu_en   <= 1'b0;
      fu_ctrl <= 4'd0;
      fu_a    <= 32'd0;
      fu_b    <= 32'd0;
      tag_q   <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          fu_en <= 1'b0;
          if (accept) begin
            state   <= ST_ISSUE;
            fu_en   <= 1'b1;
            fu_ctrl <= issue_ctrl;
            fu_a    <= issue_a;
            fu_b    <= issue_b;
            tag_q   <= issue_tag;
            busy    <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // Drop EN after one cycle; a held EN would re-trigger the FU.
          fu_en <= 1'b0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          fu_en <= 1'b0;
          if (fu_finish) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          fu_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage write; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {tag_q, fu_res, fu_zero, fu_overflow};
    end
  end

  // FIFO pointers, occupancy and the completed-operation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      done_cnt <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        done_cnt <= done_cnt + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The head entry is shown straight from storage, so it stays put until popped.
  assign head     = mem[rd_ptr];
  assign wb_valid = (count != '0);
  assign {wb_tag, wb_data, wb_zero, wb_overflow} = head;

endmodule

// File: tb/tb_fu_alu_issue_ctrl.sv
// Bench for fu_alu_issue_ctrl: a behavioural FU with programmable latency,
// directed issue vectors, and a scoreboard that checks every writeback pop.
module tb_fu_alu_issue_ctrl;

  localparam int TAG_W    = 5;
  localparam int WB_DEPTH = 2;
  localparam int ENT_W    = TAG_W + 34;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_BOUT = 4'b1100;

  logic             clk;
  logic             rst_n;
  logic             issue_valid;
  logic             issue_ready;
  logic [3:0]       issue_ctrl;
  logic [31:0]      issue_a;
  logic [31:0]      issue_b;
  logic [TAG_W-1:0] issue_tag;
  logic             fu_en;
  logic [3:0]       fu_ctrl;
  logic [31:0]      fu_a;
  logic [31:0]      fu_b;
  logic [31:0]      fu_res;
  logic             fu_zero;
  logic             fu_overflow;
  logic             fu_finish;
  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;
  logic             wb_zero;
  logic             wb_overflow;
  logic             busy;
  logic [15:0]      done_cnt;

  // FU model and stray-pulse generator each own one term of fu_finish.
  logic model_fin;
  logic stray_fin;
  assign fu_finish = model_fin | stray_fin;

  // wb_ready modes: 0 always ready, 1 manual pulse, 2 ready only on finish cycles.
  int   rdy_mode;
  logic rdy_pulse;
  assign wb_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? fu_finish : rdy_pulse;

  int fu_lat;
  int n_cmp;
  int n_bad;
  int exp_done;
  logic [ENT_W-1:0] exp_q[$];

  fu_alu_issue_ctrl #(.TAG_W(TAG_W), .WB_DEPTH(WB_DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_ctrl  (issue_ctrl),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .issue_tag   (issue_tag),
    .fu_en       (fu_en),
    .fu_ctrl     (fu_ctrl),
    .fu_a        (fu_a),
    .fu_b        (fu_b),
    .fu_res      (fu_res),
    .fu_zero     (fu_zero),
    .fu_overflow (fu_overflow),
    .fu_finish   (fu_finish),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
    .wb_zero     (wb_zero),
    .wb_overflow (wb_overflow),
    .busy        (busy),
    .done_cnt    (done_cnt)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Behavioural FU: sees EN, waits fu_lat cycles, pulses finish with the result.
  initial begin
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        o;
    model_fin   = 1'b0;
    fu_res      = 32'd0;
    fu_zero     = 1'b0;
    fu_overflow = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && fu_en) begin
        c = fu_ctrl;
        a = fu_a;
        b = fu_b;
        @(posedge clk);
        repeat (fu_lat - 1) @(posedge clk);
        #1;
        case (c)
          OP_ADD:  begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
          OP_SUB:  begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
          OP_BOUT: begin r = b;     o = 1'b0; end
          default: begin r = 32'd0; o = 1'b0; end
        endcase
        fu_res      = r;
        fu_zero     = (r == 32'd0);
        fu_overflow = o;
        model_fin   = 1'b1;
        @(posedge clk);
        #1 model_fin = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every writeback transfer pops one expected entry.
  initial begin
    logic [ENT_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wb_unexpected: got tag %0d data 0x%08h, expected no entry", wb_tag, wb_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_tag",      32'(wb_tag),      32'(e[ENT_W-1 -: TAG_W]));
          check("wb_data",     wb_data,          e[33:2]);
          check("wb_zero",     32'(wb_zero),     32'(e[1]));
          check("wb_overflow", 32'(wb_overflow), 32'(e[0]));
        end
      end
    end
  end

  // Offer one operation and return 1 time unit after the accepting edge.
  task automatic issue_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t, input logic [31:0] r,
                          input logic z, input logic o);
    int w;
    exp_q.push_back({t, r, z, o});
    exp_done++;
    @(negedge clk);
    issue_valid = 1'b1;
    issue_ctrl  = c;
    issue_a     = a;
    issue_b     = b;
    issue_tag   = t;
    w = 0;
    while (!issue_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!issue_ready) begin
      timeout_fail("issue_accept");
      issue_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 issue_valid = 1'b0;
    end
  endtask

  // Follow one operation from acceptance to its writeback appearance.
  task automatic watch_op(input int exp_lat);
    int cyc;
    int en_cnt;
    int idle_cnt;
    cyc = 0;
    en_cnt = 0;
    idle_cnt = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (wb_valid) break;
      if (fu_en) en_cnt++;
      if (!busy) idle_cnt++;
    end
    check("latency",      32'(cyc),      32'(exp_lat));
    check("fu_en_pulses", 32'(en_cnt),   32'd1);
    check("busy_gaps",    32'(idle_cnt), 32'd0);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy || wb_valid) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) timeout_fail("drain");
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (busy) timeout_fail("wait_idle");
  endtask

  // Directed test sequence.
  initial begin
    int wv;
    n_cmp       = 0;
    n_bad       = 0;
    exp_done    = 0;
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_ctrl  = 4'd0;
    issue_a     = 32'd0;
    issue_b     = 32'd0;
    issue_tag   = '0;
    rdy_mode    = 0;
    rdy_pulse   = 1'b0;
    stray_fin   = 1'b0;
    fu_lat      = 1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_wb_valid",    32'(wb_valid),    32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_fu_en",       32'(fu_en),       32'd0);
    check("rst_done_cnt",    32'(done_cnt),    32'd0);
    check("rst_fu_ctrl",     32'(fu_ctrl),     32'd0);
    check("rst_fu_a",        fu_a,             32'd0);
    check("rst_fu_b",        fu_b,             32'd0);

    // Single ADD with writeback always ready.
    issue_op(OP_ADD, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0, 1'b0);
    watch_op(3);
    drain();
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    // Zero and overflow flags, plus a pass-B operation.
    issue_op(OP_SUB, 32'd9, 32'd9, 5'd4, 32'd0, 1'b1, 1'b0);
    watch_op(3);
    issue_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd5, 32'h8000_0000, 1'b0, 1'b1);
    watch_op(3);
    issue_op(OP_BOUT, 32'd1234, 32'hCAFE_F00D, 5'd6, 32'hCAFE_F00D, 1'b0, 1'b0);
    watch_op(3);
    drain();
    check("t2_done_cnt", 32'(done_cnt), 32'd4);

    // Backpressure: two results fill the FIFO, the third waits for a pop.
    @(posedge clk);
    #1 rdy_mode = 1;
    issue_op(OP_ADD, 32'd1,  32'd2, 5'd7, 32'd3, 1'b0, 1'b0);
    issue_op(OP_SUB, 32'd10, 32'd3, 5'd8, 32'd7, 1'b0, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);
    check("t3_full_ready", 32'(issue_ready), 32'd0);
    check("t3_full_valid", 32'(wb_valid),    32'd1);
    check("t3_full_done",  32'(done_cnt),    32'd6);
    fork
      issue_op(OP_ADD, 32'd100, 32'd200, 5'd9, 32'd300, 1'b0, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 rdy_pulse = 1'b1;
        @(posedge clk);
        #1 rdy_pulse = 1'b0;
      end
    join
    wait_idle();
    check("t3_after_pop_ready", 32'(issue_ready), 32'd0);
    @(posedge clk);
    #1 rdy_mode = 0;
    drain();
    check("t3_done_cnt", 32'(done_cnt), 32'd7);

    // Slow FU, then a stray finish pulse while idle.
    fu_lat = 4;
    issue_op(OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd10, 32'd0, 1'b1, 1'b0);
    watch_op(6);
    drain();
    fu_lat = 1;
    @(posedge clk);
    #1 stray_fin = 1'b1;
    @(posedge clk);
    #1 stray_fin = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_stray_valid", 32'(wb_valid), 32'd0);
    check("t4_stray_busy",  32'(busy),     32'd0);
    check("t4_done_cnt",    32'(done_cnt), 32'd8);

    // Same-edge push and pop with one entry resident; pointers wrap repeatedly.
    @(posedge clk);
    #1 rdy_mode = 1;
    issue_op(OP_ADD, 32'd1, 32'd1, 5'd11, 32'd2, 1'b0, 1'b0);
    wait_idle();
    @(posedge clk);
    #1 rdy_mode = 2;
    issue_op(OP_ADD, 32'd16,  32'd1,  5'd12, 32'd17,  1'b0, 1'b0);
    issue_op(OP_SUB, 32'd50,  32'd8,  5'd13, 32'd42,  1'b0, 1'b0);
    issue_op(OP_ADD, 32'd250, 32'd6,  5'd14, 32'd256, 1'b0, 1'b0);
    issue_op(OP_SUB, 32'd3,   32'd3,  5'd15, 32'd0,   1'b1, 1'b0);
    issue_op(OP_BOUT, 32'd0,  32'h55AA_55AA, 5'd16, 32'h55AA_55AA, 1'b0, 1'b0);
    issue_op(OP_SUB, 32'h8000_0000, 32'd1, 5'd17, 32'h7FFF_FFFF, 1'b0, 1'b1);
    wait_idle();
    check("t5_one_left_valid", 32'(wb_valid),     32'd1);
    check("t5_one_left_queue", 32'(exp_q.size()), 32'd1);
    @(posedge clk);
    #1 rdy_mode = 0;
    drain();
    check("t5_done_cnt", 32'(done_cnt), 32'd15);

    // Reset while WAIT is active with one result queued.
    @(posedge clk);
    #1 rdy_mode = 1;
    issue_op(OP_ADD, 32'd2, 32'd2, 5'd20, 32'd4, 1'b0, 1'b0);
    wait_idle();
    fu_lat = 4;
    issue_op(OP_ADD, 32'd3, 32'd3, 5'd21, 32'd6, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_fu_en",    32'(fu_en),    32'd0);
    check("t6_rst_wb_valid", 32'(wb_valid), 32'd0);
    check("t6_rst_busy",     32'(busy),     32'd0);
    check("t6_rst_done_cnt", 32'(done_cnt), 32'd0);
    exp_q.delete();
    exp_done = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_ready", 32'(issue_ready), 32'd1);
    wv = 0;
    repeat (6) begin
      @(negedge clk);
      if (wb_valid) wv++;
    end
    check("t6_no_stale", 32'(wv), 32'd0);
    fu_lat = 1;
    @(posedge clk);
    #1 rdy_mode = 0;
    issue_op(OP_ADD, 32'd40, 32'd2, 5'd22, 32'd42, 1'b0, 1'b0);
    watch_op(3);
    drain();
    check("t6_done_cnt", 32'(done_cnt), 32'd1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
